uart_rx_fifo: RTL and testbench

Second-generation parametrised UART receiver with a runtime-configurable frame format and a built-in receive FIFO.
- Frame format: 5..DATA_WIDTH data bits, LSB/MSB first, parity none/even/odd, 1 or 2 stop bits.
- Adds start-bit glitch rejection, framing-error and overrun detection, and buffering of FIFO_DEPTH words in front of a valid/ready consumer.
- Sits between the pad-side rxd line and the UART core / bus-side register block.

---
 rtl/uart_rx_pkg.sv | 36 +++
 rtl/uart_sync_fifo.sv | 52 +++++
 rtl/uart_rx_fifo.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive path: FSM states, frame config and the received-word layout.
// UART_RX_WORD_T(W) builds the word struct for any data width; rx_word_t is the 8-bit default.
`ifndef UART_RX_PKG_SV
`define UART_RX_PKG_SV

`define UART_RX_WORD_T(W) struct packed { logic frame_err; logic parity_err; logic [(W)-1:0] data; }

package uart_rx_pkg;

    localparam int MIN_DATA_BITS      = 5;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    typedef `UART_RX_WORD_T(DEFAULT_DATA_WIDTH) rx_word_t;

    typedef struct packed {
        logic msb_first;
        logic parity_on;
        logic parity_odd;
        logic two_stop;
    } rx_cfg_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

`endif

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO; a push while full is accepted only
// when a pop frees a slot in the same cycle.
module uart_sync_fifo
    import uart_rx_pkg::*;
#(
    parameter type word_t = rx_word_t,
    parameter int  DEPTH  = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  word_t         push_data,
    input  logic          pop,
    output word_t         head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    word_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            push_ok;
    logic            pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with runtime frame format, glitch/framing/overrun detection and an RX FIFO.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote over three clocks ending at the sample point.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  CLK_FREQ   = 100_000_000,
    parameter int  FIFO_DEPTH = 16,
    localparam int DIV_WIDTH  = $clog2((CLK_FREQ / 300) * 2) + 1,
    localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1),
    localparam int BITS_WIDTH = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic [DIV_WIDTH-1:0]  cfg_pulse_width,
    input  logic [BITS_WIDTH-1:0] cfg_data_bits,
    input  logic                  cfg_msb_first,
    input  logic                  cfg_parity_on,
    input  logic                  cfg_parity_odd,
    input  logic                  cfg_two_stop,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_parity_err,
    output logic                  m_frame_err,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  fifo_count,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic                  rx_busy
);

    typedef `UART_RX_WORD_T(DATA_WIDTH) word_t;

    logic                  sync1_reg, sync2_reg, prev_reg;
    rx_state_t             state_reg, state_next;
    logic [DIV_WIDTH-1:0]  cnt_reg, cnt_next;
    logic [DIV_WIDTH-1:0]  pw_reg, pw_next;
    logic [BITS_WIDTH-1:0] nbits_reg, nbits_next;
    logic [BITS_WIDTH-1:0] bit_idx_reg, bit_idx_next;
    rx_cfg_t               cfg_reg, cfg_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next, data_upd;
    logic                  parity_err_reg, parity_err_next;
    logic                  frame_err_reg, frame_err_next;
    logic                  stop_idx_reg, stop_idx_next;
    logic                  overrun_reg;
    logic                  sample_bit, sample_tick, start_edge, last_data, push, drop;
    logic [BITS_WIDTH-1:0] nbits_clamped, bit_pos;
    word_t                 push_word, head_word;
    logic                  fifo_full, fifo_empty;

`ifdef UART_RX_MAJORITY_EN
    logic prev2_reg;
    assign sample_bit = majority3(prev2_reg, prev_reg, sync2_reg);
`else
    assign sample_bit = sync2_reg;
`endif

    // prev_reg doubles as the edge detector and the second vote in majority mode
    assign start_edge  = prev_reg & ~sync2_reg;
    assign sample_tick = (cnt_reg == '0);
    assign last_data   = (bit_idx_reg == nbits_reg - BITS_WIDTH'(1));
    assign bit_pos     = cfg_reg.msb_first ? (nbits_reg - BITS_WIDTH'(1) - bit_idx_reg) : bit_idx_reg;
    assign nbits_clamped = (cfg_data_bits < BITS_WIDTH'(MIN_DATA_BITS)) ? BITS_WIDTH'(MIN_DATA_BITS) :
                           (cfg_data_bits > BITS_WIDTH'(DATA_WIDTH))    ? BITS_WIDTH'(DATA_WIDTH)    :
                           cfg_data_bits;

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_data_upd
        assign data_upd[gi] = (bit_pos == BITS_WIDTH'(gi)) ? sample_bit : data_reg[gi];
    end

    assign push_word = '{frame_err: frame_err_reg | ~sample_bit, parity_err: parity_err_reg, data: data_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg      <= 1'b1;
            sync2_reg      <= 1'b1;
            prev_reg       <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
            prev2_reg      <= 1'b1;
`endif
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            pw_reg         <= '0;
            nbits_reg      <= '0;
            bit_idx_reg    <= '0;
            cfg_reg        <= '0;
            data_reg       <= '0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            stop_idx_reg   <= 1'b0;
        end else begin
            sync1_reg      <= rxd;
            sync2_reg      <= sync1_reg;
            prev_reg       <= sync2_reg;
`ifdef UART_RX_MAJORITY_EN
            prev2_reg      <= prev_reg;
`endif
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            pw_reg         <= pw_next;
            nbits_reg      <= nbits_next;
            bit_idx_reg    <= bit_idx_next;
            cfg_reg        <= cfg_next;
            data_reg       <= data_next;
            parity_err_reg <= parity_err_next;
            frame_err_reg  <= frame_err_next;
            stop_idx_reg   <= stop_idx_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        pw_next         = pw_reg;
        nbits_next      = nbits_reg;
        bit_idx_next    = bit_idx_reg;
        cfg_next        = cfg_reg;
        data_next       = data_reg;
        parity_err_next = parity_err_reg;
        frame_err_next  = frame_err_reg;
        stop_idx_next   = stop_idx_reg;
        push            = 1'b0;

        if (state_reg != ST_IDLE) cnt_next = sample_tick ? pw_reg : cnt_reg - DIV_WIDTH'(1);

        case (state_reg)
            ST_IDLE: begin
                if (start_edge) begin
                    state_next           = ST_START;
                    cnt_next             = cfg_pulse_width >> 1;
                    pw_next              = cfg_pulse_width;
                    nbits_next           = nbits_clamped;
                    cfg_next.msb_first   = cfg_msb_first;
                    cfg_next.parity_on   = cfg_parity_on;
                    cfg_next.parity_odd  = cfg_parity_odd;
                    cfg_next.two_stop    = cfg_two_stop;
                    bit_idx_next         = '0;
                    data_next            = '0;
                    parity_err_next      = 1'b0;
                    frame_err_next       = 1'b0;
                    stop_idx_next        = 1'b0;
                end
            end
            ST_START: begin
                if (sample_tick) state_next = sample_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (sample_tick) begin
                    data_next    = data_upd;
                    bit_idx_next = bit_idx_reg + BITS_WIDTH'(1);
                    if (last_data) state_next = cfg_reg.parity_on ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (sample_tick) begin
                    parity_err_next = sample_bit ^ (^data_reg) ^ cfg_reg.parity_odd;
                    state_next      = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample_tick) begin
                    frame_err_next = frame_err_reg | ~sample_bit;
                    // leave mid-stop so the next start edge is caught without slipping
                    if (!cfg_reg.two_stop || stop_idx_reg) begin
                        push       = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    uart_sync_fifo #(
        .word_t (word_t),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_word),
        .pop       (m_ready),
        .head      (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign drop = push && fifo_full && !(m_ready && m_valid);

    always_ff @(posedge clk) begin
        if (rst)              overrun_reg <= 1'b0;
        else if (drop)        overrun_reg <= 1'b1;
        else if (overrun_clr) overrun_reg <= 1'b0;
    end

    assign m_valid      = !fifo_empty;
    assign m_data       = m_valid ? head_word.data : '0;
    assign m_parity_err = m_valid & head_word.parity_err;
    assign m_frame_err  = m_valid & head_word.frame_err;
    assign overrun      = overrun_reg;
    assign rx_busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: P=10 bit period, FIFO_DEPTH=4, one line per checked transaction.
module tb_uart_rx_fifo;

    localparam int DW   = 8;
    localparam int DEPTH = 4;
    localparam int DIVW = $clog2((100_000_000 / 300) * 2) + 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int BW   = $clog2(DW + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rxd = 1'b1;
    logic [DIVW-1:0] cfg_pulse_width = DIVW'(9);
    logic [BW-1:0]   cfg_data_bits = BW'(8);
    logic            cfg_msb_first = 1'b0;
    logic            cfg_parity_on = 1'b0;
    logic            cfg_parity_odd = 1'b0;
    logic            cfg_two_stop = 1'b0;
    logic [DW-1:0]   m_data;
    logic            m_parity_err;
    logic            m_frame_err;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [CW-1:0]   fifo_count;
    logic            overrun;
    logic            overrun_clr = 1'b0;
    logic            rx_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DATA_WIDTH (DW),
        .CLK_FREQ   (100_000_000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rxd             (rxd),
        .cfg_pulse_width (cfg_pulse_width),
        .cfg_data_bits   (cfg_data_bits),
        .cfg_msb_first   (cfg_msb_first),
        .cfg_parity_on   (cfg_parity_on),
        .cfg_parity_odd  (cfg_parity_odd),
        .cfg_two_stop    (cfg_two_stop),
        .m_data          (m_data),
        .m_parity_err    (m_parity_err),
        .m_frame_err     (m_frame_err),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .fifo_count      (fifo_count),
        .overrun         (overrun),
        .overrun_clr     (overrun_clr),
        .rx_busy         (rx_busy)
    );

    task automatic set_cfg(input int nb, input bit msb, input bit par_on, input bit par_odd, input bit two_stop);
        cfg_data_bits  = BW'(nb);
        cfg_msb_first  = msb;
        cfg_parity_on  = par_on;
        cfg_parity_odd = par_odd;
        cfg_two_stop   = two_stop;
    endtask

    // Drives one frame at 10 clocks per bit; frame cycle c starts #1 after the c-th posedge.
    task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_last,
                              input bit end_level, input int pop_cycle, input int glitch_cycle);
        logic bits[$];
        int   nb;
        int   t;
        nb = int'(cfg_data_bits);
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(cfg_msb_first ? d[nb-1-i] : d[i]);
        if (cfg_parity_on) bits.push_back((^d) ^ cfg_parity_odd ^ par_flip);
        if (cfg_two_stop) bits.push_back(1'b1);
        bits.push_back(stop_last);
        t = bits.size();
        @(posedge clk); #1 rxd = bits[0];
        for (int c = 1; c < t * 10 + 20; c++) begin
            @(posedge clk); #1;
            rxd = (c < t * 10) ? bits[c/10] : end_level;
            if (c == glitch_cycle) rxd = 1'b0;
            if (pop_cycle >= 0) m_ready = (c == pop_cycle);
        end
    endtask

    task automatic do_pop();
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk); #1 m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || fifo_count !== '0 || overrun !== 1'b0 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%0b count=%0d overrun=%0b busy=%0b, expected 0/0/0/0", m_valid, fifo_count, overrun, rx_busy);
        end
        checks++;
        if (m_data !== 8'h00 || m_parity_err !== 1'b0 || m_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: data=%02h perr=%0b ferr=%0b, expected 00/0/0", m_data, m_parity_err, m_frame_err);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("reset: valid=%0b count=%0d busy=%0b", m_valid, fifo_count, rx_busy);
    endtask

    task automatic test_basic_8n1();
        logic [9:0] fr;
        fr = {1'b1, 8'hA5, 1'b0};
        set_cfg(8, 0, 0, 0, 0);
        @(posedge clk); #1 rxd = fr[0];
        for (int c = 1; c < 110; c++) begin
            @(posedge clk); #1;
            rxd = (c < 100) ? fr[c/10] : 1'b1;
            if (c == 97) begin
                checks++;
                if (m_valid !== 1'b0 || rx_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_before_push: valid=%0b busy=%0b, expected valid=0 busy=1", m_valid, rx_busy);
                end
            end
            if (c == 98) begin
                checks++;
                if (m_valid !== 1'b1 || rx_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_latency: valid=%0b busy=%0b, expected valid=1 busy=0", m_valid, rx_busy);
                end
                checks++;
                if (m_data !== 8'hA5 || m_parity_err !== 1'b0 || m_frame_err !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_word: data=%02h perr=%0b ferr=%0b, expected A5/0/0", m_data, m_parity_err, m_frame_err);
                end
            end
        end
        $display("basic 8N1: data=%02h valid=%0b count=%0d", m_data, m_valid, fifo_count);
        do_pop();
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || fifo_count !== '0 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL basic_drained: valid=%0b count=%0d data=%02h, expected 0/0/00", m_valid, fifo_count, m_data);
        end
    endtask

    task automatic test_parity();
        set_cfg(8, 0, 1, 0, 0);
        send_frame(8'h37, 1'b1, 1'b1, 1'b1, -1, -1);
        @(negedge clk);
        $display("8E1 bad parity: data=%02h perr=%0b ferr=%0b", m_data, m_parity_err, m_frame_err);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h37 || m_parity_err !== 1'b1 || m_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_even_bad: valid=%0b data=%02h perr=%0b ferr=%0b, expected 1/37/1/0", m_valid, m_data, m_parity_err, m_frame_err);
        end
        do_pop();
        set_cfg(8, 0, 1, 1, 0);
        send_frame(8'h37, 1'b0, 1'b1, 1'b1, -1, -1);
        @(negedge clk);
        $display("8O1 good parity: data=%02h perr=%0b ferr=%0b", m_data, m_parity_err, m_frame_err);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h37 || m_parity_err !== 1'b0 || m_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_odd_good: valid=%0b data=%02h perr=%0b ferr=%0b, expected 1/37/0/0", m_valid, m_data, m_parity_err, m_frame_err);
        end
        do_pop();
    endtask

    task automatic test_msb_two_stop();
        set_cfg(7, 1, 0, 0, 1);
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, -1, -1);
        @(negedge clk);
        $display("7N2 msb: data=%02h perr=%0b ferr=%0b", m_data, m_parity_err, m_frame_err);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h55 || m_parity_err !== 1'b0 || m_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL msb_2stop: valid=%0b data=%02h perr=%0b ferr=%0b, expected 1/55/0/0", m_valid, m_data, m_parity_err, m_frame_err);
        end
        do_pop();
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1, -1);
        repeat (60) @(posedge clk);
        @(negedge clk);
        $display("7N2 bad stop2 + held low: data=%02h ferr=%0b count=%0d", m_data, m_frame_err, fifo_count);
        checks++;
        if (m_data !== 8'h55 || m_frame_err !== 1'b1 || m_parity_err !== 1'b0) begin
            errors++;
            $display("FAIL frame_err: data=%02h perr=%0b ferr=%0b, expected 55/0/1", m_data, m_parity_err, m_frame_err);
        end
        checks++;
        if (fifo_count !== CW'(1) || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL break_no_retrigger: count=%0d busy=%0b, expected 1/0", fifo_count, rx_busy);
        end
        do_pop();
        rxd = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_glitch();
        set_cfg(8, 0, 0, 0, 0);
        @(posedge clk); #1 rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_start_seen: busy=%0b, expected 1", rx_busy);
        end
        rxd = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        $display("glitch: busy=%0b count=%0d valid=%0b", rx_busy, fifo_count, m_valid);
        checks++;
        if (rx_busy !== 1'b0 || fifo_count !== '0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject: busy=%0b count=%0d valid=%0b, expected 0/0/0", rx_busy, fifo_count, m_valid);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_q[4];
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h06};
        set_cfg(8, 0, 0, 0, 0);
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b1, -1, -1);
        @(negedge clk);
        checks++;
        if (fifo_count !== CW'(4) || overrun !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full: count=%0d overrun=%0b, expected 4/0", fifo_count, overrun);
        end
        send_frame(8'h05, 1'b0, 1'b1, 1'b1, -1, -1);
        @(negedge clk);
        $display("overrun: count=%0d overrun=%0b head=%02h", fifo_count, overrun, m_data);
        checks++;
        if (fifo_count !== CW'(4) || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: count=%0d overrun=%0b, expected 4/1", fifo_count, overrun);
        end
        @(posedge clk); #1 overrun_clr = 1'b1;
        @(posedge clk); #1 overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clr: overrun=%0b, expected 0", overrun);
        end
        send_frame(8'h06, 1'b0, 1'b1, 1'b1, 97, -1);
        @(negedge clk);
        $display("full push+pop: count=%0d overrun=%0b head=%02h", fifo_count, overrun, m_data);
        checks++;
        if (fifo_count !== CW'(4) || overrun !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d overrun=%0b, expected 4/0", fifo_count, overrun);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            $display("pop %0d: data=%02h valid=%0b", i, m_data, m_valid);
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_q[i]) begin
                errors++;
                $display("FAIL pop_order[%0d]: valid=%0b data=%02h, expected 1/%02h", i, m_valid, m_data, exp_q[i]);
            end
            do_pop();
        end
        @(negedge clk);
        checks++;
        if (fifo_count !== '0 || m_valid !== 1'b0 || m_data !== 8'h00) begin
            errors++;
            $display("FAIL fifo_empty: count=%0d valid=%0b data=%02h, expected 0/0/00", fifo_count, m_valid, m_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        int glitch;
`ifdef UART_RX_MAJORITY_EN
        glitch = 35;
`else
        glitch = -1;
`endif
        set_cfg(8, 0, 0, 0, 0);
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, -1, -1);
        @(posedge clk); #1 rxd = 1'b0;
        repeat (10) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (rx_busy !== 1'b1 || fifo_count !== CW'(1)) begin
            errors++;
            $display("FAIL mid_frame_busy: busy=%0b count=%0d, expected 1/1", rx_busy, fifo_count);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rx_busy !== 1'b0 || fifo_count !== '0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_frame_reset: busy=%0b count=%0d valid=%0b, expected 0/0/0", rx_busy, fifo_count, m_valid);
        end
        rst = 1'b0;
        repeat (5) @(posedge clk);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, -1, glitch);
        @(negedge clk);
        $display("after reset: data=%02h perr=%0b ferr=%0b count=%0d", m_data, m_parity_err, m_frame_err, fifo_count);
        checks++;
        if (fifo_count !== CW'(1) || m_data !== 8'h3C || m_parity_err !== 1'b0 || m_frame_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_frame: count=%0d data=%02h perr=%0b ferr=%0b, expected 1/3C/0/0", fifo_count, m_data, m_parity_err, m_frame_err);
        end
        do_pop();
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity();
        test_msb_two_stop();
        test_glitch();
        test_overrun();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
